// File: rtl/rs232_uart_rx_pkg.sv
// Shared types and constants for the RS-232 receive capture path.
// RS232_RX_PARITY_EN adds the PARITY state encoding (8E1 frames).
package rs232_uart_rx_pkg;

    localparam int unsigned OVERSAMPLE         = 16;
    localparam int unsigned PHASE_W            = 4;
    localparam int unsigned SAMPLE_PH_A        = 7;
    localparam int unsigned SAMPLE_PH_B        = 8;
    localparam int unsigned DECIDE_PH          = 9;
    localparam int unsigned LAST_PH            = OVERSAMPLE - 1;
    localparam int unsigned DATA_BITS          = 8;
    localparam int unsigned BIT_IDX_W          = 3;
    localparam int unsigned BAUD_W             = 16;
    localparam int unsigned ENTRY_W            = DATA_BITS + 1;
    localparam int unsigned DEFAULT_FIFO_DEPTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_DATA       = 3'd2,
`ifdef RS232_RX_PARITY_EN
        ST_PARITY     = 3'd3,
`endif
        ST_STOP       = 3'd4,
        ST_BREAK_WAIT = 3'd5
    } rx_state_t;

    typedef struct packed {
        logic                 err;
        logic [DATA_BITS-1:0] data;
    } rx_entry_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rs232_uart_rx_if.sv
// Received-byte stream: valid/ready handshake carrying one byte plus its frame error flag.
interface rs232_uart_rx_if;
    logic [7:0] out_data;
    logic       out_frame_err;
    logic       out_valid;
    logic       out_ready;

    modport master (output out_data, output out_frame_err, output out_valid, input out_ready);
    modport slave  (input out_data, input out_frame_err, input out_valid, output out_ready);
endinterface

// File: rtl/rs232_byte_fifo.sv
// Generic first-word-fall-through synchronous FIFO with a registered head entry.
// The head register holds the last popped (or reset) value while empty.
module rs232_byte_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d, level_d;
    logic [WIDTH-1:0] head_d;
    logic             push_acc_c, pop_acc_c;

    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign pop_acc_c  = pop & ~empty;
    assign push_acc_c = push & (~full | pop_acc_c);

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(push_acc_c);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop_acc_c);
        level_d  = wr_ptr_d - rd_ptr_d;
        head_d   = rdata;
        if (level_d != '0) begin
            if (push_acc_c && (wr_ptr_q == rd_ptr_d))
                head_d = wdata;
            else
                head_d = mem[rd_ptr_d[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc_c)
            mem[wr_ptr_q[AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            rdata    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level    <= level_d;
            full     <= (level_d == (AW+1)'(DEPTH));
            empty    <= (level_d == '0);
            rdata    <= head_d;
        end
    end

endmodule

// File: rtl/rs232_uart_rx.sv
// 16x oversampling RS-232 receiver (8N1, LSB first) feeding a byte FIFO stream.
// Define RS232_RX_PARITY_EN to receive 8E1 frames with parity folded into the error flag.
module rs232_uart_rx
    import rs232_uart_rx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int unsigned FIFO_AW    = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [BAUD_W-1:0]   baud_div,
    input  logic                rxd,
    rs232_uart_rx_if.master     byte_if,
    output logic [FIFO_AW:0]    fifo_level,
    output logic                overflow,
    input  logic                clear_stats
);

    rx_state_t              state_q, state_d;
    logic [1:0]             sync_q;
    logic                   rx_prev_q;
    logic [BAUD_W-1:0]      tick_cnt_q, tick_cnt_d;
    logic [PHASE_W-1:0]     phase_q, phase_d;
    logic [1:0]             samp_q, samp_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
`ifdef RS232_RX_PARITY_EN
    logic                   par_err_q, par_err_d;
`endif
    logic                   rx_s, tick_c, maj_c, decide_c, end_c, in_frame_c;
    logic                   push_c, pop_c, fifo_full, fifo_empty;
    rx_entry_t              entry_c, head_c;

    assign rx_s     = sync_q[1];
    assign tick_c   = (tick_cnt_q == '0);
    assign maj_c    = majority3(samp_q[0], samp_q[1], rx_s);
    assign decide_c = tick_c && (phase_q == PHASE_W'(DECIDE_PH));
    assign end_c    = tick_c && (phase_q == PHASE_W'(LAST_PH));

    // Stop sample low marks a framing error; parity mismatch joins it when enabled
    assign entry_c.data = shift_q;
`ifdef RS232_RX_PARITY_EN
    assign entry_c.err  = ~maj_c | par_err_q;
`else
    assign entry_c.err  = ~maj_c;
`endif

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_c ? baud_div : tick_cnt_q - BAUD_W'(1);
        phase_d    = phase_q;
        samp_d     = samp_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
`ifdef RS232_RX_PARITY_EN
        par_err_d  = par_err_q;
`endif
        push_c     = 1'b0;
        in_frame_c = (state_q != ST_IDLE) && (state_q != ST_BREAK_WAIT);

        if (in_frame_c && tick_c) begin
            phase_d = phase_q + PHASE_W'(1);
            if (phase_q == PHASE_W'(SAMPLE_PH_A)) samp_d[0] = rx_s;
            if (phase_q == PHASE_W'(SAMPLE_PH_B)) samp_d[1] = rx_s;
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    state_d    = ST_START;
                    phase_d    = '0;
                    tick_cnt_d = baud_div;
                end
            end
            ST_START: begin
                if (decide_c && maj_c) begin
                    state_d = ST_IDLE;
                end else if (end_c) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (decide_c)
                    shift_d = {maj_c, shift_q[DATA_BITS-1:1]};
                if (end_c) begin
                    if (bit_idx_q == BIT_IDX_W'(DATA_BITS - 1))
`ifdef RS232_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    else
                        bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                end
            end
`ifdef RS232_RX_PARITY_EN
            ST_PARITY: begin
                if (decide_c)
                    par_err_d = maj_c ^ (^shift_q);
                if (end_c)
                    state_d = ST_STOP;
            end
`endif
            // Leave at the stop decision so a back-to-back start edge is not missed
            ST_STOP: begin
                if (decide_c) begin
                    push_c  = 1'b1;
                    state_d = maj_c ? ST_IDLE : ST_BREAK_WAIT;
                end
            end
            ST_BREAK_WAIT: begin
                if (rx_s)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            sync_q     <= 2'b11;
            rx_prev_q  <= 1'b1;
            tick_cnt_q <= '0;
            phase_q    <= '0;
            samp_q     <= '0;
            shift_q    <= '0;
            bit_idx_q  <= '0;
`ifdef RS232_RX_PARITY_EN
            par_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sync_q     <= {sync_q[0], rxd};
            rx_prev_q  <= rx_s;
            tick_cnt_q <= tick_cnt_d;
            phase_q    <= phase_d;
            samp_q     <= samp_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
`ifdef RS232_RX_PARITY_EN
            par_err_q  <= par_err_d;
`endif
        end
    end

    assign pop_c = ~fifo_empty & byte_if.out_ready;

    rs232_byte_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset_n),
        .push  (push_c),
        .wdata (entry_c),
        .pop   (pop_c),
        .rdata (head_c),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign byte_if.out_data      = head_c.data;
    assign byte_if.out_frame_err = head_c.err;
    assign byte_if.out_valid     = ~fifo_empty;

    // Sticky drop flag; a new drop beats a coincident clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            overflow <= 1'b0;
        else
            overflow <= (push_c & fifo_full & ~pop_c) | (overflow & ~clear_stats);
    end

endmodule

// File: tb/tb_rs232_uart_rx.sv
// Self-checking bench for rs232_uart_rx: directed frames plus randomized traffic against a byte-queue model.
module tb_rs232_uart_rx;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rxd;
    logic [15:0] baud_div;
    logic        clear_stats;
    logic [4:0]  fifo_level;
    logic        overflow;

    rs232_uart_rx_if byte_if();

    always #5 clk = ~clk;

    rs232_uart_rx #(.FIFO_DEPTH(16), .FIFO_AW(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .baud_div    (baud_div),
        .rxd         (rxd),
        .byte_if     (byte_if),
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .clear_stats (clear_stats)
    );

    int         n_pass  = 0;
    int         n_total = 0;
    logic [8:0] exp_q[$];
    logic       exp_ov;
    logic [8:0] last_pop;
    int         n_pops;
    int         n_model;
    int         ready_mode;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // Model: every frame the receiver should accept, in order; a full FIFO drops and flags overflow
    task automatic model_push(input logic [7:0] d, input logic err);
        if (exp_q.size() >= DEPTH) begin
            exp_ov = 1'b1;
        end else begin
            exp_q.push_back({err, d});
            n_model++;
        end
    endtask

    task automatic drive(input logic v, input int n);
        rxd = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
        int   bp;
        logic err;
        bp  = 16 * (int'(baud_div) + 1);
        err = ~stop;
        drive(1'b0, bp);
        for (int i = 0; i < 8; i++) drive(d[i], bp);
`ifdef RS232_RX_PARITY_EN
        drive((^d) ^ par_flip, bp);
        err = err | par_flip;
`else
        err = err | (par_flip & 1'b0);
`endif
        model_push(d, err);
        drive(stop, bp);
        rxd = 1'b1;
        if (!stop) drive(1'b1, bp);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 20000 && (exp_q.size() != 0 || byte_if.out_valid); i++)
            @(posedge clk);
        #1;
        chk({name, "_drained"}, exp_q.size(), 0);
        chk({name, "_level0"}, fifo_level, 0);
    endtask

    // Stream checker: each accepted beat must equal the model's oldest entry
    always @(negedge clk) begin
        if (reset_n === 1'b1 && byte_if.out_valid === 1'b1 && byte_if.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL spurious_beat: got 0x%0h, required no beat",
                         {byte_if.out_frame_err, byte_if.out_data});
            end else begin
                chk("beat", {byte_if.out_frame_err, byte_if.out_data}, exp_q.pop_front());
            end
            last_pop = {byte_if.out_frame_err, byte_if.out_data};
            n_pops++;
        end
    end

    initial begin
        byte_if.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                1:       byte_if.out_ready = 1'b1;
                2:       byte_if.out_ready = ($urandom_range(0, 3) != 0);
                default: byte_if.out_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         pre;
        logic [7:0] d;
        logic       st, pf;
        reset_n = 1'b0; rxd = 1'b1; baud_div = 16'd3; clear_stats = 1'b0;
        ready_mode = 1; exp_ov = 1'b0; n_pops = 0; n_model = 0; last_pop = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", byte_if.out_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_data", byte_if.out_data, 0);
        chk("rst_err", byte_if.out_frame_err, 0);
        reset_n = 1'b1;
        drive(1'b1, 20);

        send_frame(8'h55, 1'b1, 1'b0);
        wait_drain("basic");
        chk("basic_byte", last_pop, 9'h055);
        chk("basic_pops", n_pops, 1);

        drive(1'b0, 20);
        drive(1'b1, 3 * 64);
        chk("glitch_valid", byte_if.out_valid, 0);
        chk("glitch_level", fifo_level, 0);
        chk("glitch_pops", n_pops, 1);
        send_frame(8'hC3, 1'b1, 1'b0);
        wait_drain("after_glitch");
        chk("after_glitch_byte", last_pop, 9'h0C3);

        send_frame(8'hA3, 1'b0, 1'b0);
        wait_drain("frame_err");
        chk("frame_err_byte", last_pop, 9'h1A3);

        pre = n_pops;
        model_push(8'h00, 1'b1);
        drive(1'b0, 30 * 64);
        drive(1'b1, 64);
        wait_drain("break");
        chk("break_byte", last_pop, 9'h100);
        chk("break_once", n_pops, pre + 1);
        send_frame(8'h7E, 1'b1, 1'b0);
        wait_drain("after_break");
        chk("after_break_byte", last_pop, 9'h07E);

        ready_mode = 0;
        drive(1'b1, 4);
        for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1, 1'b0);
        drive(1'b1, 64);
        chk("ovf_level", fifo_level, 16);
        chk("ovf_flag", overflow, 1);
        chk("ovf_model", overflow, exp_ov);
        ready_mode = 1;
        wait_drain("ovf_drain");
        chk("ovf_last", last_pop, 9'h00F);
        chk("ovf_sticky", overflow, 1);
        clear_stats = 1'b1;
        @(posedge clk);
        #1;
        clear_stats = 1'b0;
        exp_ov = 1'b0;
        chk("ovf_cleared", overflow, exp_ov);

        ready_mode = 0;
        drive(1'b1, 4);
        send_frame(8'h5A, 1'b1, 1'b0);
        drive(1'b1, 10);
        chk("pre_rst_valid", byte_if.out_valid, 1);
        chk("pre_rst_data", byte_if.out_data, 8'h5A);
        d = 8'h3C;
        drive(1'b0, 64);
        for (int i = 0; i < 4; i++) drive(d[i], 64);
        drive(d[4], 32);
        #3;
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", byte_if.out_valid, 0);
        chk("midrst_level", fifo_level, 0);
        chk("midrst_overflow", overflow, 0);
        chk("midrst_data", byte_if.out_data, 0);
        chk("midrst_err", byte_if.out_frame_err, 0);
        n_model = n_model - exp_q.size();
        exp_q.delete();
        exp_ov = 1'b0;
        rxd = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b1;
        drive(1'b1, 64);
        ready_mode = 1;
        send_frame(8'h81, 1'b1, 1'b0);
        wait_drain("after_rst");
        chk("after_rst_byte", last_pop, 9'h081);

`ifdef RS232_RX_PARITY_EN
        send_frame(8'h01, 1'b1, 1'b1);
        wait_drain("par_bad");
        chk("par_bad_byte", last_pop, 9'h101);
        send_frame(8'h01, 1'b1, 1'b0);
        wait_drain("par_good");
        chk("par_good_byte", last_pop, 9'h001);
`endif

        ready_mode = 2;
        for (int k = 0; k < 30; k++) begin
            baud_div = 16'($urandom_range(0, 3));
            d  = 8'($urandom);
            st = ($urandom_range(0, 4) != 0);
            pf = ($urandom_range(0, 3) == 0);
            send_frame(d, st, pf);
            if ($urandom_range(0, 1) != 0) drive(1'b1, $urandom_range(1, 100));
        end
        wait_drain("random");
        chk("total_beats", n_pops, n_model);
        chk("final_overflow", overflow, exp_ov);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rs232_uart_rx.md
Name: rs232_uart_rx

Overview:
- Upstream capture stage for the RS-232 bridge: deserialises the sniffed A-side RXD line (8N1, LSB first) using 16x oversampling.
- Queues received bytes in a small FIFO and presents them as a valid/ready byte stream.
- The downstream USB IN packer drains that stream into endpoint buffers.
- The line itself stays a pure passthrough; this block only observes it.

Parameters:
- FIFO_DEPTH, 16: byte FIFO entries; power of two, 4..256.
- FIFO_AW, 4: log2(FIFO_DEPTH).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- baud_div  in  16  oversample tick period minus 1; tick every baud_div+1 clocks
- rxd  in  1  raw serial line, idle high, asynchronous to clk
- out_data  out  8  head-of-FIFO byte
- out_frame_err  out  1  head byte had a bad stop bit (or parity, see Optional Feature)
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts the head entry when out_valid & out_ready
- fifo_level  out  FIFO_AW+1  current occupancy
- overflow  out  1  sticky: a byte was dropped because the FIFO was full
- clear_stats  in  1  single-cycle pulse; clears overflow

Behaviour:
- Reset values:
  - out_data=0, out_frame_err=0, out_valid=0, fifo_level=0, overflow=0.
  - Synchroniser flops = 1, state = IDLE, tick counter = 0.
  - Reset mid-frame discards the partial byte and all FIFO contents.
- Synchronisation:
  - rxd passes through 2 flops before any use.
  - Total input latency is 2 clocks.
- Tick generator:
  - Down-counter reloads baud_div and emits a 1-clock tick at 0.
  - baud_div=0 gives a tick every clock.
  - baud_div is sampled at each reload; changing it mid-frame is undefined.
- Phase counter:
  - 4-bit counter advances per tick; one bit = 16 ticks.
  - Bit value = majority of synced samples taken at phases 7, 8 and 9.
- States: IDLE, START, DATA, STOP, BREAK_WAIT.
  - IDLE: on a synced falling edge, clear the phase counter, restart the tick counter, go to START.
  - START: at the phase-9 decision, a majority-1 result is a false start (glitch): return to IDLE with no push. Otherwise go to DATA at the end of the bit (phase 15).
  - DATA: shift in 8 bits LSB first, bit index 0..7. After bit 7 ends, go to STOP.
  - STOP: decide at phase 9 and push {err, byte} in the same clock. err=1 when the stop sample is 0.
    - Stop=1: go to IDLE immediately, without waiting for the rest of the stop bit, so back-to-back frames are caught.
    - Stop=0: go to BREAK_WAIT.
  - BREAK_WAIT: stay until the synced line reads 1, then go to IDLE. A held-low line yields exactly one byte (0x00, err=1).
- FIFO:
  - Synchronous, first-word-fall-through, 9 bits wide.
  - out_valid rises the clock after a push into an empty FIFO.
  - Pop happens when out_valid & out_ready.
- Push while full:
  - Without a same-cycle pop, the byte is dropped and overflow is set.
  - With a same-cycle pop, the push is accepted and the level is unchanged.
- Simultaneous push and pop with the FIFO non-full: level unchanged.
- Pointers wrap modulo FIFO_DEPTH. fifo_level is derived from pointers carrying one extra wrap bit.
- clear_stats coincident with a new overflow event: overflow ends the cycle set (set wins).
- out_data and out_frame_err hold their values while out_valid=0 (last popped or reset value); the consumer must not rely on them.

Optional Feature:
- Macro RS232_RX_PARITY_EN.
- Defined:
  - Frame is 8E1. A PARITY state sits between DATA and STOP and samples the same way.
  - out_frame_err = stop error OR (XOR of data and parity bit != 0).
- Undefined: 8N1 only; PARITY state and its logic are absent.

Decomposition:
- rs232_pkg.vh (shared include):
  - State encodings.
  - OVERSAMPLE=16.
  - Sample phases 7/8/9 and the decision phase 9.
  - Default FIFO_DEPTH.
- Sub-module rs232_byte_fifo: generic FWFT sync FIFO with width/depth parameters, level output, and push/pop/full/empty. The receiver FSM stays in rs232_uart_rx.

Test Plan:
- Basic byte: baud_div=3 (1 bit = 64 clocks), send 0x55 with stop=1, out_ready=1 -> one beat: out_data=0x55, out_frame_err=0, fifo_level returns to 0.
- Glitch rejection: rxd low for 20 clocks in IDLE -> no push; out_valid stays 0; the next genuine 0xC3 frame is received correctly.
- Framing error and break:
  - 0xA3 with stop=0 -> 0xA3, err=1.
  - Line held low for 30 bit times -> exactly one 0x00, err=1; the next 0x7E after the line returns high is received with err=0.
- Overflow: out_ready=0, send 17 back-to-back bytes 0x00..0x10 -> fifo_level=16, overflow=1. Draining yields 0x00..0x0F in order. clear_stats -> overflow=0.
- Reset mid-frame: assert reset_n=0 during DATA bit 4 of 0x3C -> all outputs return to reset values immediately; the following 0x81 is received intact.
- Parity (RS232_RX_PARITY_EN): 0x01 with parity bit 0 -> err=1; 0x01 with parity bit 1 -> err=0.
